// File: rtl/histogram_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Package     : histogram_pkg                                          |
// | Description : Shared FSM encoding and default bin/total widths for   |
// |               the histogram accumulator and its readout block.       |
// | Revision    : 1.0  initial release                                   |
// +----------------------------------------------------------------------+
package histogram_pkg;

  // Accumulator sequencing: zero-fill, wait, read bin, write bin+1.
  typedef enum logic [1:0] {
    ST_CLEAR = 2'd0,
    ST_IDLE  = 2'd1,
    ST_RD    = 2'd2,
    ST_WR    = 2'd3
  } state_t;

  // Width of one bin counter (saturating increment wraps never).
  localparam int HIST_BIN_W   = 16;
  // Number of bins, one per ADC code.
  localparam int HIST_DEPTH   = 1024;
  // Width of the saturating accepted-sample counter.
  localparam int HIST_TOTAL_W = 32;

endpackage
`default_nettype wire

// File: rtl/histogram_accumulator_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Interface   : histogram_accumulator_if                               |
// | Description : Sample stream handshake plus histogram RAM port A.     |
// |               master = sample source / RAM side, slave = accumulator.|
// | Revision    : 1.0  initial release                                   |
// +----------------------------------------------------------------------+
interface histogram_accumulator_if
  import histogram_pkg::*;
#(
  parameter int WIDTH = HIST_BIN_W,
  parameter int DEPTH = HIST_DEPTH
);

  localparam int ADDR_W = $clog2(DEPTH);

  logic              sample_valid;
  logic              sample_ready;
  logic [ADDR_W-1:0] sample_code;
  logic [ADDR_W-1:0] ram_addr_a;
  logic [WIDTH-1:0]  ram_din_a;
  logic              ram_wen;
  logic [WIDTH-1:0]  ram_dout_a;

  modport master (
    output sample_valid,
    output sample_code,
    output ram_dout_a,
    input  sample_ready,
    input  ram_addr_a,
    input  ram_din_a,
    input  ram_wen
  );

  modport slave (
    input  sample_valid,
    input  sample_code,
    input  ram_dout_a,
    output sample_ready,
    output ram_addr_a,
    output ram_din_a,
    output ram_wen
  );

endinterface
`default_nettype wire

// File: rtl/histogram_accumulator_clear_sweeper.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : clear_sweeper                                          |
// | Description : Address counter for the zero-fill sweep. Presents the  |
// |               address to write this cycle and flags the last one.    |
// | Revision    : 1.0  initial release                                   |
// +----------------------------------------------------------------------+
module clear_sweeper #(
  parameter int DEPTH = 1024
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     en,
  input  logic                     restart,
  output logic [$clog2(DEPTH)-1:0] addr,
  output logic                     done
);

  localparam int ADDR_W = $clog2(DEPTH);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  logic [ADDR_W-1:0] cnt;

  // A restart forces address 0 in the very cycle it is requested.
  assign addr = restart ? '0 : cnt;
  assign done = (addr == LAST_ADDR);

  // Step through the bins while enabled; park at 0 otherwise so every sweep starts from bin 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (en && !done) begin
      cnt <= addr + ADDR_W'(1);
    end else begin
      cnt <= '0;
    end
  end

endmodule
`default_nettype wire

// File: rtl/histogram_accumulator.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : histogram_accumulator                                  |
// | Description : Turns a stream of ADC codes into per-code hit counts   |
// |               by read-increment-write on RAM port A; zero-fills the  |
// |               RAM after reset or on request.                         |
// | Revision    : 1.0  initial release                                   |
// +----------------------------------------------------------------------+
module histogram_accumulator
  import histogram_pkg::*;
#(
  parameter int WIDTH   = HIST_BIN_W,
  parameter int DEPTH   = HIST_DEPTH,
  parameter int TOTAL_W = HIST_TOTAL_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clear_req,
  input  logic               acq_en,
  histogram_accumulator_if.slave bus,
  output logic               clear_busy,
  output logic [TOTAL_W-1:0] total_count,
  output logic               bin_saturated
);

  localparam int ADDR_W = $clog2(DEPTH);
  localparam logic [WIDTH-1:0]   BIN_MAX      = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0]   BIN_NEAR_MAX = BIN_MAX - WIDTH'(1);
  localparam logic [TOTAL_W-1:0] TOTAL_MAX    = {TOTAL_W{1'b1}};

  state_t             state, state_nx;
  logic [ADDR_W-1:0]  addr_q, addr_nx;
  logic [WIDTH-1:0]   din_q, din_nx;
  logic               wen_q, wen_nx;
  logic [TOTAL_W-1:0] total_q, total_nx;
  logic               sat_q, sat_nx;
  logic               pend_q, pend_nx;

  logic               ready;
  logic               sweep_en;
  logic               sweep_restart;
  logic               sweep_done;
  logic [ADDR_W-1:0]  sweep_addr;
  logic               in_range;
  logic [WIDTH-1:0]   bin_inc;

  assign ready         = (state == ST_IDLE) && acq_en;
  assign sweep_en      = (state == ST_CLEAR);
  assign sweep_restart = sweep_en && clear_req;
  assign bin_inc       = (bus.ram_dout_a == BIN_MAX) ? BIN_MAX : bus.ram_dout_a + WIDTH'(1);

  clear_sweeper #(
    .DEPTH (DEPTH)
  ) u_sweeper (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (sweep_en),
    .restart (sweep_restart),
    .addr    (sweep_addr),
    .done    (sweep_done)
  );

  // Codes beyond the last bin only exist when DEPTH is not a power of two.
  generate
    if (DEPTH == (1 << ADDR_W)) begin : g_full_range
      assign in_range = 1'b1;
    end else begin : g_partial_range
      assign in_range = ({1'b0, addr_q} < (ADDR_W + 1)'(DEPTH));
    end
  endgenerate

  // State and registered RAM/status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_CLEAR;
      addr_q  <= '0;
      din_q   <= '0;
      wen_q   <= 1'b0;
      total_q <= '0;
      sat_q   <= 1'b0;
      pend_q  <= 1'b0;
    end else begin
      state   <= state_nx;
      addr_q  <= addr_nx;
      din_q   <= din_nx;
      wen_q   <= wen_nx;
      total_q <= total_nx;
      sat_q   <= sat_nx;
      pend_q  <= pend_nx;
    end
  end

  // Next state and next register values; a clear seen mid-RMW waits until the write is issued.
  always_comb begin
    state_nx = state;
    addr_nx  = addr_q;
    din_nx   = din_q;
    wen_nx   = 1'b0;
    total_nx = total_q;
    sat_nx   = sat_q;
    pend_nx  = pend_q;
    case (state)
      ST_CLEAR: begin
        wen_nx   = 1'b1;
        din_nx   = '0;
        addr_nx  = sweep_addr;
        total_nx = '0;
        sat_nx   = 1'b0;
        pend_nx  = 1'b0;
        if (sweep_done) begin
          state_nx = ST_IDLE;
        end
      end
      ST_IDLE: begin
        if (clear_req) begin
          state_nx = ST_CLEAR;
        end else if (bus.sample_valid && ready) begin
          addr_nx  = bus.sample_code;
          state_nx = ST_RD;
        end
      end
      ST_RD: begin
        if (clear_req) begin
          pend_nx = 1'b1;
        end
        state_nx = ST_WR;
      end
      ST_WR: begin
        if (in_range) begin
          din_nx = bin_inc;
          wen_nx = 1'b1;
          if (bus.ram_dout_a >= BIN_NEAR_MAX) begin
            sat_nx = 1'b1;
          end
          if (total_q != TOTAL_MAX) begin
            total_nx = total_q + TOTAL_W'(1);
          end
        end
        pend_nx  = 1'b0;
        state_nx = (pend_q || clear_req) ? ST_CLEAR : ST_IDLE;
      end
      default: begin
        state_nx = ST_CLEAR;
      end
    endcase
  end

  assign bus.sample_ready = ready;
  assign bus.ram_addr_a   = addr_q;
  assign bus.ram_din_a    = din_q;
  assign bus.ram_wen      = wen_q;
  assign clear_busy       = (state == ST_CLEAR);
  assign total_count      = total_q;
  assign bin_saturated    = sat_q;

endmodule
`default_nettype wire

// File: doc/histogram_accumulator.md
Name: histogram_accumulator

Overview:
- Upstream of the dual-port histogram RAM. Converts a stream of ADC output codes into per-code hit counts for code-density (DNL/INL) analysis.
- Each accepted code triggers a read-increment-write on RAM port A; port B stays free for readout.
- Also zero-fills the RAM after reset or on request.

Parameters:
- WIDTH, 16, RAM word width = bin counter width.
- DEPTH, 1024, number of bins = 2^ADC bits; ADDR_W = $clog2(DEPTH).
- TOTAL_W, 32, width of the total-samples counter.

Ports:
- clk  in  1  system clock (100 MHz).
- rst_n  in  1  asynchronous active-low reset.
- clear_req  in  1  one-cycle pulse: zero all bins and counters.
- acq_en  in  1  acquisition enable; samples ignored while low.
- sample_valid  in  1  sample_code is valid this cycle.
- sample_code  in  ADDR_W  ADC code = bin address.
- sample_ready  out  1  high only in IDLE with acq_en=1; a sample is accepted on valid&ready.
- ram_addr_a  out  ADDR_W  RAM port A address, registered.
- ram_din_a  out  WIDTH  RAM port A write data, registered.
- ram_wen  out  1  RAM write enable, registered.
- ram_dout_a  in  WIDTH  RAM port A read data; valid one clk after ram_addr_a changes (synchronous read).
- clear_busy  out  1  high while the clear sweep runs.
- total_count  out  TOTAL_W  accepted samples since last clear, saturating.
- bin_saturated  out  1  sticky: some bin hit 2^WIDTH-1.

Behaviour:
- Reset (async assert, sync release):
  - Outputs: ram_addr_a=0, ram_din_a=0, ram_wen=0, sample_ready=0, total_count=0, bin_saturated=0, clear_busy=1.
  - FSM enters CLEAR, so the histogram always starts zeroed.
- FSM states: CLEAR, IDLE, RD, WR.
- CLEAR:
  - ram_wen=1, ram_din_a=0, ram_addr_a steps 0..DEPTH-1, one address per clk.
  - Last write at DEPTH-1, then IDLE. Duration is exactly DEPTH cycles.
  - total_count and bin_saturated are zeroed on entry.
  - clear_req during CLEAR restarts the sweep at address 0.
- IDLE:
  - ram_wen=0; sample_ready=acq_en.
  - On valid&ready: latch code, ram_addr_a<=sample_code, go to RD.
  - clear_req in IDLE: go to CLEAR. clear_req wins over a simultaneous sample, which is dropped.
- RD: wait one cycle for ram_dout_a; go to WR.
- WR:
  - ram_din_a <= ram_dout_a+1, saturating at 2^WIDTH-1; ram_wen<=1 for one cycle; same address.
  - If the pre-increment value is ≥2^WIDTH-2, set bin_saturated.
  - total_count++ (saturates at 2^TOTAL_W-1); return to IDLE.
- Throughput: one sample per 3 clks when back-to-back (ready low in RD and WR). Fits the 10 MHz sample tick with margin.
- Latency: accept edge → write edge is 2 clks; the updated value is readable on port B from the following cycle.
- clear_req during RD/WR: latched as pending; the RMW completes, then CLEAR starts instead of IDLE. A sample is never half-written.
- acq_en falling during RD/WR: the in-flight sample completes; no further accepts.
- Repeated identical codes need no forwarding, since each RMW finishes before the next read.
- Codes ≥DEPTH are impossible by width. With non-power-of-2 DEPTH, such codes are accepted but not written, and total_count is not incremented.
- Reset mid-RMW: the write is abandoned and the RAM re-cleared by CLEAR after reset.

Decomposition:
- Shared package (histogram_pkg): FSM state encoding (CLEAR/IDLE/RD/WR) and the saturating-increment width constants, reused by the readout block.
- One natural sub-module: clear_sweeper, the address counter plus done flag for the CLEAR sweep. Everything else stays inline.

Test Plan:
- Reset release → clear_busy=1 for exactly 1024 clks, ram_wen=1 with addresses 0..1023 and din=0; sample_ready=0 throughout, then 1 with acq_en=1.
- Codes 5, 5, 5 offered back-to-back → ready pattern 1,0,0 per sample; bin 5 reads 3 via port B; total_count=3; accept-to-write = 2 clks.
- Ramp of codes 0..1023 repeated 10× at the 10 MHz tick → every bin reads 10; total_count=10240.
- Bin 7 preloaded to 0xFFFE, then two hits → reads 0xFFFF after both; bin_saturated=1 after the first hit; the second hit does not wrap.
- clear_req asserted in RD of a code-9 sample → the WR to bin 9 completes, then the CLEAR sweep; afterwards bin 9=0 and total_count=0.
- rst_n asserted mid-WR, then released → outputs return to reset values immediately; after the sweep all bins read 0.
